// File: rtl/race_time_decoder.sv
// Race-logic temporal-to-binary reader: time-stamps the first falling edge of each line after start.
// Latency: a line falling k cycles after start reports k-1; out_valid rises one cycle after the window closes.
// Backpressure: the result is held in HOLD until out_valid&out_ready, and start is ignored until then.
// Optional feature: define RACE_DEC_SORT_CHECK_EN to add the sorted_ok output (non-decreasing times check).
module race_time_decoder #(
  parameter int N     = 16,
  parameter int TW    = 6,
  parameter int MAX_T = 63,
  parameter int SYNC  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    lines_in,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*TW-1:0] times_out,
  output logic [N-1:0]    missed,
  output logic [N-1:0]    early
`ifdef RACE_DEC_SORT_CHECK_EN
  ,
  output logic            sorted_ok
`endif
);

  localparam int AW = $clog2(SYNC) + 1;

  typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;

  state_t          state_q;
  logic [N-1:0]    sync_q [SYNC];
  logic [N-1:0]    ls;
  logic [AW-1:0]   arm_q;
  logic [TW-1:0]   cnt_q;
  logic [TW-1:0]   times_q [N];
  logic [TW-1:0]   times_d [N];
  logic [N-1:0]    cap_q, cap_d;
  logic [N-1:0]    missed_d, early_d;
  logic            done;

  assign ls = sync_q[SYNC-1];

  // Synchronizer chain; idles high so reset never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC; s++) sync_q[s] <= '1;
    end else begin
      sync_q[0] <= lines_in;
      for (int s = 1; s < SYNC; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Next capture state: early marking on the last ARM cycle, first-fall-wins in RUN, timeout fill.
  always_comb begin
    times_d  = times_q;
    cap_d    = cap_q;
    missed_d = missed;
    early_d  = early;
    done     = 1'b0;
    case (state_q)
      ARM: begin
        if (arm_q == AW'(SYNC - 1)) begin
          for (int i = 0; i < N; i++) begin
            if (!ls[i]) begin
              cap_d[i]   = 1'b1;
              early_d[i] = 1'b1;
              times_d[i] = '0;
            end
          end
        end
      end
      RUN: begin
        for (int i = 0; i < N; i++) begin
          if (!ls[i] && !cap_q[i]) begin
            cap_d[i]   = 1'b1;
            times_d[i] = cnt_q;
          end
        end
        if (&cap_d) begin
          done = 1'b1;
        end else if (cnt_q == TW'(MAX_T)) begin
          done = 1'b1;
          for (int i = 0; i < N; i++) begin
            if (!cap_d[i]) begin
              missed_d[i] = 1'b1;
              times_d[i]  = TW'(MAX_T);
            end
          end
        end
      end
      default: ;
    endcase
  end

`ifdef RACE_DEC_SORT_CHECK_EN
  logic sort_d;

  // Ordering check on the values about to be latched for HOLD.
  always_comb begin
    sort_d = 1'b1;
    for (int i = 1; i < N; i++) begin
      if (times_d[i] < times_d[i-1]) sort_d = 1'b0;
    end
  end

  // Ordering flag, refreshed only when a result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        sorted_ok <= 1'b0;
    else if (state_q == RUN && done)   sorted_ok <= sort_d;
  end
`endif

  // Measurement FSM with registered busy/out_valid and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      arm_q     <= '0;
      cnt_q     <= '0;
      cap_q     <= '0;
      missed    <= '0;
      early     <= '0;
      for (int i = 0; i < N; i++) times_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ARM;
            busy    <= 1'b1;
            arm_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
            missed  <= '0;
            early   <= '0;
            for (int i = 0; i < N; i++) times_q[i] <= '0;
          end
        end
        ARM: begin
          cap_q   <= cap_d;
          early   <= early_d;
          times_q <= times_d;
          if (arm_q == AW'(SYNC - 1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else begin
            arm_q <= arm_q + 1'b1;
          end
        end
        RUN: begin
          cap_q   <= cap_d;
          missed  <= missed_d;
          times_q <= times_d;
          if (done) begin
            state_q   <= HOLD;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else if (cnt_q != TW'(MAX_T)) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flatten per-line times onto the output bus.
  always_comb begin
    times_out = '0;
    for (int i = 0; i < N; i++) times_out[i*TW +: TW] = times_q[i];
  end

endmodule
